// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the CPU load/store path. It accepts one request
// through a valid/ready handshake, performs the access LATENCY cycles after
// the accept edge, and holds the response until the requester takes it.
// Byte, halfword and word accesses use RV32I lane placement and sign/zero
// extension.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   req_valid      request present
//   req_ready      responder can accept a request (IDLE, and rst low)
//   req_write      1 = store, 0 = load
//   req_addr       byte address; word index = addr[ADDR_WIDTH+1:2]
//   req_wdata      store data, right-aligned
//   req_maskmode   0 = byte, 1 = halfword, 2 = word, 3 = illegal
//   req_uext       loads only: 1 = zero-extend, 0 = sign-extend
//   resp_valid     response present
//   resp_ready     requester accepts the response
//   resp_rdata     load result (0 for stores and errors)
//   resp_err       access was misaligned or illegal
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_maskmode,
  input  logic                  req_uext,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            mm_q, mm_d;
  logic                  uext_q, uext_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  // Array is zero at time 0 and deliberately untouched by reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  // Upper address bits only select aliases of the same word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  // ---------------------------------------------------------------
  // Access datapath (operates on captured request fields)
  // ---------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            lane;
  logic [DATA_WIDTH-1:0] rd_word, sh_byte, sh_half;
  logic [DATA_WIDTH-1:0] ld_val, wd_rep, merged;
  logic [3:0]            be;
  logic                  acc_err, fire, mem_we;

  assign widx    = addr_q[AW-1:2];
  assign lane    = addr_q[1:0];
  assign rd_word = mem_q[widx];
  assign sh_byte = rd_word >> {lane, 3'b000};
  assign sh_half = rd_word >> {lane[1], 4'b0000};
  assign fire    = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we  = fire && wr_q && !acc_err;

  always_comb begin
    acc_err = 1'b0;
    unique case (mm_q)
      2'd0:    acc_err = 1'b0;
      2'd1:    acc_err = lane[0];
      2'd2:    acc_err = |lane;
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    ld_val = rd_word;
    unique case (mm_q)
      2'd0: ld_val = uext_q ? {24'd0, sh_byte[7:0]}
                            : {{24{sh_byte[7]}}, sh_byte[7:0]};
      2'd1: ld_val = uext_q ? {16'd0, sh_half[15:0]}
                            : {{16{sh_half[15]}}, sh_half[15:0]};
      default: ld_val = rd_word;
    endcase
  end

  // Replicate store data across lanes, then pick lanes by byte enable.
  always_comb begin
    be     = 4'b0000;
    wd_rep = wdata_q;
    unique case (mm_q)
      2'd0: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{wdata_q[15:0]}};
      end
      2'd2: begin
        be     = 4'b1111;
        wd_rep = wdata_q;
      end
      default: begin
        be     = 4'b0000;
        wd_rep = wdata_q;
      end
    endcase
  end

  always_comb begin
    merged = rd_word;
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = wd_rep[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[widx] <= merged;
  end

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mm_q    <= 2'd0;
      uext_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mm_q    <= mm_d;
      uext_q  <= uext_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mm_d    = mm_q;
    uext_d  = uext_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          wr_d    = req_write;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          mm_d    = req_maskmode;
          uext_d  = req_uext;
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Access happens on this edge; the store lands in the array now.
          err_d   = acc_err;
          rdata_d = (acc_err || wr_q) ? '0 : ld_val;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------
  always_comb begin
    req_ready  = (state_q == S_IDLE) && !rst;
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_uext;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_maskmode;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  // LATENCY=1 instance
  logic        v1, rdy1, w1, ue1, rv1, rr1, re1;
  logic [31:0] a1, wd1, rd1;
  logic [1:0]  mm1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_maskmode(req_maskmode),
    .req_uext(req_uext),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(rdy1), .req_write(w1),
    .req_addr(a1), .req_wdata(wd1), .req_maskmode(mm1),
    .req_uext(ue1),
    .resp_valid(rv1), .resp_ready(rr1),
    .resp_rdata(rd1), .resp_err(re1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance with resp_ready high.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] mm, input logic ue,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    lat = 99;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_maskmode = mm; req_uext = ue;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin lat = k; break; end
    end
    chk({tag, "_lat"}, lat, 32'd2);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(posedge clk); #1;   // response handshake
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    req_maskmode = 0; req_uext = 0; resp_ready = 1'b1;
    v1 = 0; w1 = 0; a1 = 0; wd1 = 0; mm1 = 0; ue1 = 0; rr1 = 1'b1;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err",   {31'd0, resp_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Word store / load
    xfer("sw10", 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0);
    xfer("lw10", 0, 32'h10, 32'h0,        2'd2, 0, 32'hDEADBEEF, 0);

    // Byte store and extensions
    xfer("sb21",  1, 32'h21, 32'h00000080, 2'd0, 0, 32'h0, 0);
    xfer("lb21",  0, 32'h21, 32'h0, 2'd0, 0, 32'hFFFFFF80, 0);
    xfer("lbu21", 0, 32'h21, 32'h0, 2'd0, 1, 32'h00000080, 0);
    xfer("lw20",  0, 32'h20, 32'h0, 2'd2, 0, 32'h00008000, 0);

    // Halfword store and extensions
    xfer("sh32",  1, 32'h32, 32'h00008001, 2'd1, 0, 32'h0, 0);
    xfer("lh32",  0, 32'h32, 32'h0, 2'd1, 0, 32'hFFFF8001, 0);
    xfer("lhu32", 0, 32'h32, 32'h0, 2'd1, 1, 32'h00008001, 0);
    xfer("lw30",  0, 32'h30, 32'h0, 2'd2, 0, 32'h80010000, 0);

    // Errors: no write, rdata 0
    xfer("lw11_err", 0, 32'h11, 32'h0,        2'd2, 0, 32'h0, 1);
    xfer("sh13_err", 1, 32'h13, 32'h0000FFFF, 2'd1, 0, 32'h0, 1);
    xfer("mm3_err",  1, 32'h10, 32'h00000000, 2'd3, 0, 32'h0, 1);
    xfer("lw10_b",   0, 32'h10, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0);
    // 0x410 wraps onto word 4 (0x10)
    xfer("lw410_wrap", 0, 32'h410, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0);

    // Backpressure
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 0; req_addr = 32'h10; req_maskmode = 2'd2; req_uext = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 2); req_addr = 32'h20;
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, 32'hDEADBEEF);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    xfer("bp_next", 0, 32'h20, 32'h0, 2'd2, 0, 32'h00008000, 0);

    // Reset during WAIT drops the store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1; req_addr = 32'h40;
    req_wdata = 32'h12345678; req_maskmode = 2'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw_wait_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rw_ready", {31'd0, req_ready}, 32'd0);
    chk("rw_valid", {31'd0, resp_valid}, 32'd0);
    chk("rw_rdata", resp_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rw_noresp", {31'd0, resp_valid}, 32'd0);
    xfer("lw40", 0, 32'h40, 32'h0, 2'd2, 0, 32'h00000000, 0);

    // LATENCY=1 instance
    @(negedge clk);
    v1 = 1'b1; w1 = 1'b1; a1 = 32'h8; wd1 = 32'hCAFEF00D; mm1 = 2'd2;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("l1_wait", {31'd0, rv1}, 32'd0);
    @(posedge clk); #1;
    chk("l1_st_valid", {31'd0, rv1}, 32'd1);
    @(posedge clk); #1;
    v1 = 1'b1; w1 = 1'b0;
    @(posedge clk); #1;
    v1 = 1'b0;
    @(posedge clk); #1;
    chk("l1_ld_valid", {31'd0, rv1}, 32'd1);
    chk("l1_ld_rdata", rd1, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
